// File: rtl/jt12_ch_wr_pkg.sv
// Shared jt12 register-map constants and the channel-write request decode.
package jt12_ch_wr_pkg;

  localparam logic [7:0] REG_A0    = 8'hA0;
  localparam logic [7:0] REG_A4    = 8'hA4;
  localparam logic [7:0] REG_B0    = 8'hB0;
  localparam logic [7:0] REG_B4    = 8'hB4;
  localparam logic [4:0] BUSY_LOAD = 5'd31;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_FNUMLO,
    REQ_ALG,
    REQ_PMS
  } req_e;

  // Each register group spans four addresses; the low two bits select the channel.
  function automatic req_e decode_req(input logic [7:0] a);
    if (a[7:2] == REG_A0[7:2]) return REQ_FNUMLO;
    if (a[7:2] == REG_B0[7:2]) return REQ_ALG;
    if (a[7:2] == REG_B4[7:2]) return REQ_PMS;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/jt12_ch_wr_if.sv
// CPU write bus into the jt12 channel register block.
interface jt12_ch_wr_if;
  logic       cs_n;
  logic       wr_n;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs_n, wr_n, addr, din, input dout);
  modport slave  (input cs_n, wr_n, addr, din, output dout);
endinterface

// File: rtl/jt12_ch_wr_busy.sv
// Busy flag with a preloadable down-counter clocked by the chip enable.
module jt12_busy_cnt
  import jt12_ch_wr_pkg::*;
(
  input  logic rst,
  input  logic clk,
  input  logic cen,
  input  logic load,
  output logic busy
);

  logic [4:0] cnt;

  // A load wins over a coincident decrement; busy drops on the cen that finds cnt at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= BUSY_LOAD;
      busy <= 1'b1;
    end else if (cen && busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 5'd1;
    end
  end

endmodule

// File: rtl/jt12_ch_wr.sv
// Channel register write path: CPU write detect, address latch, request decode
// and cen-aligned one-clock update strobes.
module jt12_ch_wr
  import jt12_ch_wr_pkg::*;
#(
  parameter int NUM_CH = 6
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            cen,
  jt12_ch_wr_if.slave     bus,
  output logic [2:0]      up_ch,
  output logic [5:0]      latch_fnum,
  output logic            up_fnumlo,
  output logic            up_alg,
  output logic            up_pms,
  output logic [7:0]      din_q
);

  localparam bit THREE_CH = (NUM_CH == 3);

  logic       wr_q;
  logic [7:0] addr_q;
  logic       part_q;
  logic [2:0] pend_ch;
  logic       busy;
  logic       write, addr_wr, data_wr, target_ok;
  req_e       state_q, state_d, issue;

  assign write     = !bus.cs_n && !bus.wr_n && wr_q;
  assign addr_wr   = write && !bus.addr[0];
  assign data_wr   = write &&  bus.addr[0];
  assign target_ok = (addr_q[1:0] != 2'd3) && !(THREE_CH && part_q);
  assign bus.dout  = {busy, 7'b0};

  // A data write always overrides the pending request, even when it decodes to nothing.
  always_comb begin
    state_d = state_q;
    issue   = REQ_NONE;
    if (data_wr) begin
      state_d = target_ok ? decode_req(addr_q) : REQ_NONE;
    end else if (cen && state_q != REQ_NONE) begin
      issue   = state_q;
      state_d = REQ_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= 1'b1;
      addr_q     <= '0;
      part_q     <= 1'b0;
      din_q      <= '0;
      latch_fnum <= '0;
      pend_ch    <= '0;
      up_ch      <= '0;
      state_q    <= REQ_NONE;
      up_fnumlo  <= 1'b0;
      up_alg     <= 1'b0;
      up_pms     <= 1'b0;
    end else begin
      wr_q      <= bus.wr_n;
      state_q   <= state_d;
      up_fnumlo <= (issue == REQ_FNUMLO);
      up_alg    <= (issue == REQ_ALG);
      up_pms    <= (issue == REQ_PMS);
      if (addr_wr) begin
        addr_q <= bus.din;
        part_q <= bus.addr[1];
      end
      if (data_wr) begin
        din_q   <= bus.din;
        pend_ch <= {part_q, addr_q[1:0]};
        if (target_ok && addr_q[7:2] == REG_A4[7:2])
          latch_fnum <= bus.din[5:0];
      end
      if (issue != REQ_NONE) up_ch <= pend_ch;
    end
  end

  jt12_busy_cnt u_busy (
    .rst  (rst),
    .clk  (clk),
    .cen  (cen),
    .load (data_wr),
    .busy (busy)
  );

endmodule

// File: tb/tb_jt12_ch_wr.sv
// Scoreboard bench for jt12_ch_wr: 6-channel and 3-channel instances on a shared clock.
module tb_jt12_ch_wr;

  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] ch;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b0;
  bit   cen_hold = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  jt12_ch_wr_if bus6 ();
  jt12_ch_wr_if bus3 ();

  logic [2:0] up_ch6, up_ch3;
  logic [5:0] latch6, latch3;
  logic       fl6, al6, pm6, fl3, al3, pm3;
  logic [7:0] dq6, dq3;

  jt12_ch_wr #(.NUM_CH(6)) dut6 (
    .rst(rst), .clk(clk), .cen(cen), .bus(bus6), .up_ch(up_ch6), .latch_fnum(latch6),
    .up_fnumlo(fl6), .up_alg(al6), .up_pms(pm6), .din_q(dq6));

  jt12_ch_wr #(.NUM_CH(3)) dut3 (
    .rst(rst), .clk(clk), .cen(cen), .bus(bus3), .up_ch(up_ch3), .latch_fnum(latch3),
    .up_fnumlo(fl3), .up_alg(al3), .up_pms(pm3), .din_q(dq3));

  always #5 clk = ~clk;

  // cen every fourth clock unless held off
  initial begin
    int unsigned n = 0;
    forever begin
      @(negedge clk);
      n++;
      cen = !cen_hold && (n % 4 == 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic bus_wr(input bit tgt3, input logic a1, input logic a0, input logic [7:0] d);
    @(negedge clk);
    if (tgt3) begin
      bus3.cs_n = 1'b0; bus3.wr_n = 1'b0; bus3.addr = {a1, a0}; bus3.din = d;
    end else begin
      bus6.cs_n = 1'b0; bus6.wr_n = 1'b0; bus6.addr = {a1, a0}; bus6.din = d;
    end
    @(negedge clk);
    bus3.cs_n = 1'b1; bus3.wr_n = 1'b1;
    bus6.cs_n = 1'b1; bus6.wr_n = 1'b1;
  endtask

  // Monitor: every strobe on the 6-channel instance must match the head of the queue.
  always @(negedge clk) begin
    if (fl6 || al6 || pm6) begin
      logic [1:0] kind;
      exp_t e;
      kind = pm6 ? 2'd3 : al6 ? 2'd2 : 2'd1;
      total++;
      if ((fl6 + al6 + pm6) > 1) begin
        bad++;
        $display("FAIL strobe_overlap actual=%b%b%b required=one-hot", fl6, al6, pm6);
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe actual kind=%0d ch=%0d data=%h required=none", kind, up_ch6, dq6);
      end else begin
        e = exp_q.pop_front();
        if (kind !== e.kind || up_ch6 !== e.ch || dq6 !== e.data) begin
          bad++;
          $display("FAIL strobe actual kind=%0d ch=%0d data=%h required kind=%0d ch=%0d data=%h",
                   kind, up_ch6, dq6, e.kind, e.ch, e.data);
        end
      end
    end
    if (fl3 || al3 || pm3) begin
      total++;
      bad++;
      $display("FAIL strobe3 actual=%b%b%b required=000", fl3, al3, pm3);
    end
  end

  initial begin
    int n;
    bus6.cs_n = 1'b1; bus6.wr_n = 1'b1; bus6.addr = '0; bus6.din = '0;
    bus3.cs_n = 1'b1; bus3.wr_n = 1'b1; bus3.addr = '0; bus3.din = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_dout", bus6.dout, 8'h00);
    check("rst_latch", {2'b0, latch6}, 8'h00);
    check("rst_up_ch", {5'b0, up_ch6}, 8'h00);
    check("rst_din_q", dq6, 8'h00);
    check("rst_strobes", {5'b0, fl6, al6, pm6}, 8'h00);
    check("rst_dout3", bus3.dout, 8'h00);

    // latch then fnum low on part0 ch0
    bus_wr(0, 0, 0, 8'hA4);
    bus_wr(0, 0, 1, 8'h2A);
    check("latch_2a", {2'b0, latch6}, 8'h2A);
    check("busy_set", bus6.dout, 8'h80);
    bus_wr(0, 0, 0, 8'hA0);
    exp_q.push_back('{kind: 2'd1, ch: 3'd0, data: 8'h55});
    bus_wr(0, 0, 1, 8'h55);
    repeat (8) @(negedge clk);
    check("latch_kept", {2'b0, latch6}, 8'h2A);

    // part1 pms ch1 -> up_ch 5
    bus_wr(0, 1, 0, 8'hB5);
    exp_q.push_back('{kind: 2'd3, ch: 3'd5, data: 8'hC3});
    bus_wr(0, 1, 1, 8'hC3);
    repeat (8) @(negedge clk);

    // channel 3 discarded, busy spans 32 cen
    bus_wr(0, 0, 0, 8'hA3);
    bus_wr(0, 0, 1, 8'h11);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (cen) n++;
      #1;
      if (!bus6.dout[7]) break;
    end
    check("busy_cen_count", n[7:0], 8'd32);
    check("busy_clear", bus6.dout, 8'h00);

    // last write wins while pending
    cen_hold = 1'b1;
    bus_wr(0, 0, 0, 8'hB0);
    bus_wr(0, 0, 1, 8'h07);
    bus_wr(0, 0, 0, 8'hB1);
    exp_q.push_back('{kind: 2'd2, ch: 3'd1, data: 8'h3F});
    bus_wr(0, 0, 1, 8'h3F);
    cen_hold = 1'b0;
    repeat (10) @(negedge clk);

    // reset drops a pending request
    cen_hold = 1'b1;
    bus_wr(0, 0, 0, 8'hA4);
    bus_wr(0, 0, 1, 8'h15);
    bus_wr(0, 0, 0, 8'hA0);
    bus_wr(0, 0, 1, 8'h99);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cen_hold = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_busy", bus6.dout, 8'h00);
    check("rst_mid_latch", {2'b0, latch6}, 8'h00);

    // 3-channel: part1 ignored, busy still set
    bus_wr(1, 1, 0, 8'hA4);
    bus_wr(1, 1, 1, 8'h21);
    check("nch3_busy", bus3.dout, 8'h80);
    check("nch3_latch", {2'b0, latch3}, 8'h00);

    // held-low wr_n yields one write: later din must not land
    bus_wr(1, 0, 0, 8'hA4);
    @(negedge clk);
    bus3.cs_n = 1'b0; bus3.wr_n = 1'b0; bus3.addr = 2'b01; bus3.din = 8'h05;
    @(negedge clk);
    bus3.din = 8'h3A;
    repeat (9) @(negedge clk);
    bus3.cs_n = 1'b1; bus3.wr_n = 1'b1;
    @(negedge clk);
    check("held_wr_latch", {2'b0, latch3}, 8'h05);
    check("held_wr_din_q", dq3, 8'h05);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
